// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) with a small output FIFO and sticky line-error flags.
// Optional even-parity frame format is built when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    input  logic                          clr_err,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          par_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   HALF_LOAD = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0]   BIT_LOAD  = 16'(BAUD_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd4;
`endif

    logic          sync1_q, sync1_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
    logic          push_req, frame_set, overrun_set, pop, push_ok, tick;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d, par_err_q, par_err_d, par_set;
`endif

    // Synchroniser, edge history and receive FSM next-state.
    always_comb begin
        sync1_d   = rx;
        rx_s_d    = sync1_q;
        rx_prev_d = rx_s_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        tick      = (cnt_q == 16'd0);
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // An edge is required, so a held-low line never retriggers.
                if (rx_prev_q && !rx_s_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rx_s_q) begin
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
`ifdef UART_RX_PARITY_EN
                    perr_d    = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shreg_d[bit_idx_q] = rx_s_q;
                    cnt_d              = BIT_LOAD;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PAR: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    perr_d  = (rx_s_q != ^shreg_q);
                    cnt_d   = BIT_LOAD;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = S_IDLE;
                    if (!rx_s_q) begin
                        frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (perr_q) begin
                        par_set = 1'b1;
`endif
                    end else begin
                        push_req = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers/count; a full FIFO still accepts a push when the head pops that cycle.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop         = (count_q != '0) && m_ready;
        push_ok     = push_req && ((count_q < FULL_CNT) || pop);
        overrun_set = push_req && !push_ok;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Sticky error flags; a new error in the clear cycle wins.
    always_comb begin
        frame_err_d   = frame_set   | (frame_err_q   & ~clr_err);
        overrun_err_d = overrun_set | (overrun_err_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
        par_err_d     = par_set     | (par_err_q     & ~clr_err);
`endif
    end

    // State registers; reset aborts any frame in flight and empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q        <= 1'b0;
            par_err_q     <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            perr_q        <= perr_d;
            par_err_q     <= par_err_d;
`endif
        end
    end

    assign m_data      = mem_q[rd_ptr_q];
    assign m_valid     = (count_q != '0);
    assign fifo_count  = count_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign par_err     = par_err_q;
`else
    assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-level model of the receive path and FIFO,
// per-cycle compare on the falling edge, directed scenarios plus random frames.
module tb_uart_rx_fifo;
    localparam int BAUD  = 8;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NB     = 10;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int NB     = 9;
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk, rst, rx, m_ready, clr_err;
    logic [7:0] m_data;
    logic       m_valid, busy, frame_err, overrun_err, par_err;
    logic [2:0] fifo_count;

    uart_rx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .clr_err(clr_err), .busy(busy), .frame_err(frame_err),
        .overrun_err(overrun_err), .par_err(par_err), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model state
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    bit   m_fe, m_oe, m_pe;
    int   ev_cyc, ev_kind, busy_from, busy_to, ready_mode;
    logic [7:0] ev_byte;
    int   vectors = 0, miscompares = 0;
    bit   pop_n, do_push, fs, os, ps;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare, then advance the model to the next rising edge.
    always @(negedge clk) begin
        if (cyc >= 2) begin
            chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < busy_to));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("overrun_err", 32'(overrun_err), 32'(m_oe));
            chk("par_err", 32'(par_err), 32'(m_pe));
        end
        if (rst) begin
            mq.delete();
            m_fe = 0; m_oe = 0; m_pe = 0;
            ev_kind = 0; busy_to = 0;
        end else begin
            pop_n = (mq.size() != 0) && m_ready;
            do_push = 0; fs = 0; os = 0; ps = 0;
            if (ev_kind != 0 && ev_cyc == cyc + 1) begin
                case (ev_kind)
                    1: if (mq.size() < DEPTH || pop_n) do_push = 1; else os = 1;
                    2: fs = 1;
                    default: ps = 1;
                endcase
            end
            if (pop_n) popped.push_back(mq.pop_front());
            if (do_push) mq.push_back(ev_byte);
            m_fe = fs | (m_fe & ~clr_err);
            m_oe = os | (m_oe & ~clr_err);
            m_pe = ps | (m_pe & ~clr_err);
        end
    end

    // Consumer ready: held low, held high, or random per cycle.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    // Drive one frame; the expected outcome lands on the edge after the stop-bit sample:
    // 2 sync edges + half bit to the start sample + one bit period per remaining bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                              input int rst_bit);
        logic bits [12];
        int s;
        @(posedge clk); #1;
        s = cyc + 1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = b[i];
        bits[9] = par_b;
        bits[NB] = stop_b;
        ev_byte   = b;
        ev_cyc    = s + 2 + BAUD/2 + NB*BAUD;
        busy_from = s + 2;
        busy_to   = ev_cyc;
        if (rst_bit >= 0)                  ev_kind = 0;
        else if (!stop_b)                  ev_kind = 2;
        else if (PAR_ON && par_b != ^b)    ev_kind = 3;
        else                               ev_kind = 1;
        for (int k = 0; k <= NB; k++) begin
            rx = bits[k];
            for (int j = 0; j < BAUD; j++) begin
                rst = (k == rst_bit + 1 && j == 0);
                if (j != 0 || k != 0) begin @(posedge clk); #1; end
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
    endtask

    task automatic glitch();
        int s;
        @(posedge clk); #1;
        s = cyc + 1;
        ev_kind = 0;
        busy_from = s + 2;
        busy_to = s + 2 + BAUD/2;
        rx = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic stp, par;
        rst = 1'b1; rx = 1'b1; clr_err = 1'b0; m_ready = 1'b0; ready_mode = 0;
        ev_kind = 0; ev_cyc = 0; busy_from = 0; busy_to = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_errs", {29'h0, frame_err, overrun_err, par_err}, 32'h0);
        rst = 1'b0;
        idle(4);

        // 1: single byte, consumer always ready
        ready_mode = 1; popped.delete();
        send_frame(8'hA5, 1'b1, ^8'hA5, -1);
        idle(3*BAUD);
        chk("t1_npop", popped.size(), 32'd1);
        if (popped.size() > 0) chk("t1_byte", 32'(popped[0]), 32'hA5);
        chk("t1_busy", 32'(busy), 32'h0);

        // 2: fill past capacity with consumer stalled
        ready_mode = 0; popped.delete();
        for (int v = 1; v <= 5; v++) begin
            b = 8'(v);
            send_frame(b, 1'b1, ^b, -1);
            idle(BAUD);
        end
        chk("t2_count", 32'(fifo_count), 32'd4);
        chk("t2_overrun", 32'(overrun_err), 32'd1);
        ready_mode = 1;
        idle(10);
        chk("t2_npop", popped.size(), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("t2_order", 32'(popped[i]), 32'(i + 1));
        pulse_clr();
        chk("t2_clr", 32'(overrun_err), 32'd0);

        // 3: bad stop bit
        popped.delete();
        send_frame(8'h3C, 1'b0, ^8'h3C, -1);
        idle(2*BAUD);
        chk("t3_frame_err", 32'(frame_err), 32'd1);
        chk("t3_npop", popped.size(), 32'd0);
        pulse_clr();
        chk("t3_clr", 32'(frame_err), 32'd0);

        // 4: short glitch
        popped.delete();
        glitch();
        idle(2*BAUD);
        chk("t4_npop", popped.size(), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // 5: reset mid-frame, then a clean byte
        popped.delete();
        send_frame(8'hFF, 1'b1, ^8'hFF, 3);
        idle(2*BAUD);
        send_frame(8'h5A, 1'b1, ^8'h5A, -1);
        idle(2*BAUD);
        chk("t5_npop", popped.size(), 32'd1);
        if (popped.size() > 0) chk("t5_byte", 32'(popped[0]), 32'h5A);

`ifdef UART_RX_PARITY_EN
        // 6: parity error then correct parity
        popped.delete();
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(2*BAUD);
        chk("t6_par_err", 32'(par_err), 32'd1);
        chk("t6_npop0", popped.size(), 32'd0);
        pulse_clr();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(2*BAUD);
        chk("t6_npop1", popped.size(), 32'd1);
        if (popped.size() > 0) chk("t6_byte", 32'(popped[0]), 32'h07);
`endif

        // random frames, random back-pressure and clears
        ready_mode = 2;
        repeat (40) begin
            b   = 8'($urandom);
            stp = ($urandom_range(0, 7) != 0);
            par = (^b) ^ ($urandom_range(0, 5) == 0);
            send_frame(b, stp, par, -1);
            idle($urandom_range(BAUD, 3*BAUD));
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end
        ready_mode = 1;
        idle(20);
        chk("final_count", 32'(fifo_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
